// File: rtl/sdpktfifo_pkg.sv
// Shared SD data-path definitions: depth/pointer-width helpers and the modular
// pointer-difference used by the data FIFOs.
package sdpktfifo_pkg;

    localparam int MAX_LGFLEN = 12;
    localparam int MAX_PW     = MAX_LGFLEN + 1;

    typedef logic [MAX_PW-1:0] ptr_t;

    function automatic int flen(input int lgflen);
        return 1 << lgflen;
    endfunction

    function automatic int ptr_width(input int lgflen);
        return lgflen + 1;
    endfunction

    // Callers zero-extend narrower pointers and truncate the result back to
    // their own width, which keeps the difference correct modulo 2^width.
    function automatic ptr_t ptr_diff(input ptr_t a, input ptr_t b);
        return a - b;
    endfunction

endpackage

// File: rtl/sdpktfifo_ram.sv
// FLEN x BW storage for sdpktfifo: one synchronous write port and one
// asynchronous read port, kept separate so a vendor RAM can replace it.
module sdpktfifo_ram #(
    parameter int BW = 32,
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [BW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [BW-1:0] rdata
);

    logic [BW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sdpktfifo.sv
// Packet-aware SD data FIFO: writes stay pending until committed or discarded.
// Define SDPKTFIFO_ERRFLAGS_EN for sticky overflow/underflow flags and i_clrerr.
module sdpktfifo
    import sdpktfifo_pkg::*;
#(
    parameter int BW     = 32,
    parameter int LGFLEN = 9,
    parameter int AF_GAP = 4,
    parameter int AE_LVL = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_wr,
    input  logic [BW-1:0]     i_data,
    input  logic              i_commit,
    input  logic              i_discard,
    output logic              o_full,
    output logic              o_afull,
    output logic [LGFLEN:0]   o_fill,
    output logic [LGFLEN:0]   o_pending,
    input  logic              i_rd,
    output logic [BW-1:0]     o_data,
    output logic              o_empty,
    output logic              o_aempty,
`ifdef SDPKTFIFO_ERRFLAGS_EN
    input  logic              i_clrerr,
    output logic              o_overflow,
    output logic              o_underflow,
`endif
    output logic [LGFLEN:0]   o_avail
);

    localparam int PW   = ptr_width(LGFLEN);
    localparam int FLEN = flen(LGFLEN);
    localparam logic [PW-1:0] FLEN_W = PW'(FLEN);
    localparam logic [PW-1:0] AF_W   = PW'(AF_GAP);
    localparam logic [PW-1:0] AE_W   = PW'(AE_LVL);

    logic [PW-1:0] wr_addr, cm_addr, rd_addr;
    logic [PW-1:0] wr_next, cm_next, rd_next;
    logic [PW-1:0] fill_next, avail_next, pend_next;
    logic          w_wr, w_rd;

    assign w_wr = i_wr && !o_full && !i_discard;
    assign w_rd = i_rd && !o_empty;

    // Discard rewinds the pending head and overrides any same-cycle commit.
    always_comb begin
        wr_next = wr_addr + PW'(w_wr);
        cm_next = cm_addr;
        rd_next = rd_addr + PW'(w_rd);
        if (i_discard) begin
            wr_next = cm_addr;
        end else if (i_commit) begin
            cm_next = wr_addr + PW'(w_wr);
        end
    end

    assign fill_next  = PW'(ptr_diff(ptr_t'(wr_next), ptr_t'(rd_next)));
    assign avail_next = PW'(ptr_diff(ptr_t'(cm_next), ptr_t'(rd_next)));
    assign pend_next  = PW'(ptr_diff(ptr_t'(wr_next), ptr_t'(cm_next)));

    // Counters and flags are registered from next-state pointers, so no flag
    // has a combinational path from i_wr or i_rd.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_addr   <= '0;
            cm_addr   <= '0;
            rd_addr   <= '0;
            o_fill    <= '0;
            o_avail   <= '0;
            o_pending <= '0;
            o_full    <= 1'b0;
            o_afull   <= 1'b0;
            o_empty   <= 1'b1;
            o_aempty  <= 1'b1;
        end else begin
            wr_addr   <= wr_next;
            cm_addr   <= cm_next;
            rd_addr   <= rd_next;
            o_fill    <= fill_next;
            o_avail   <= avail_next;
            o_pending <= pend_next;
            o_full    <= (fill_next == FLEN_W);
            o_afull   <= ((FLEN_W - fill_next) <= AF_W);
            o_empty   <= (avail_next == '0);
            o_aempty  <= (avail_next <= AE_W);
        end
    end

    sdpktfifo_ram #(
        .BW (BW),
        .AW (LGFLEN)
    ) u_ram (
        .clk   (i_clk),
        .we    (w_wr),
        .waddr (wr_addr[LGFLEN-1:0]),
        .wdata (i_data),
        .raddr (rd_addr[LGFLEN-1:0]),
        .rdata (o_data)
    );

`ifdef SDPKTFIFO_ERRFLAGS_EN
    // A set event in the same cycle as i_clrerr keeps the flag set.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            if (i_wr && o_full) begin
                o_overflow <= 1'b1;
            end else if (i_clrerr) begin
                o_overflow <= 1'b0;
            end
            if (i_rd && o_empty) begin
                o_underflow <= 1'b1;
            end else if (i_clrerr) begin
                o_underflow <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sdpktfifo.sv
// Self-checking bench for sdpktfifo (FLEN=4, AF_GAP=1, AE_LVL=1); a committed-word
// queue predicts read data, a pending queue tracks uncommitted writes.
module tb_sdpktfifo;

    localparam int BW   = 32;
    localparam int LG   = 2;
    localparam int PW   = LG + 1;
    localparam int FLEN = 4;
    localparam int AFG  = 1;
    localparam int AEL  = 1;

    logic          clk = 1'b0;
    logic          rst, wr, cm, dc, rd;
    logic [BW-1:0] din;
    logic          o_full, o_afull, o_empty, o_aempty;
    logic [PW-1:0] o_fill, o_pending, o_avail;
    logic [BW-1:0] o_data;
`ifdef SDPKTFIFO_ERRFLAGS_EN
    logic          clrerr, ovf, unf;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] pend_q[$];

    always #5 clk = ~clk;

    sdpktfifo #(.BW(BW), .LGFLEN(LG), .AF_GAP(AFG), .AE_LVL(AEL)) dut (
        .i_clk(clk), .i_reset(rst), .i_wr(wr), .i_data(din),
        .i_commit(cm), .i_discard(dc), .o_full(o_full), .o_afull(o_afull),
        .o_fill(o_fill), .o_pending(o_pending), .i_rd(rd), .o_data(o_data),
        .o_empty(o_empty), .o_aempty(o_aempty),
`ifdef SDPKTFIFO_ERRFLAGS_EN
        .i_clrerr(clrerr), .o_overflow(ovf), .o_underflow(unf),
`endif
        .o_avail(o_avail)
    );

    function automatic int m_fill();
        return exp_q.size() + pend_q.size();
    endfunction

    // One clock of stimulus; reads are scored against the committed queue.
    task automatic step(input logic w, input logic [BW-1:0] d, input logic c,
                        input logic x, input logic r);
        logic w_wr, w_rd;
        @(negedge clk);
        wr = w; din = d; cm = c; dc = x; rd = r;
        w_wr = w && (m_fill() < FLEN) && !x;
        w_rd = r && (exp_q.size() != 0);
        if (w_rd) begin
            n_checks++;
            if (o_data !== exp_q[0])
                $display("FAIL rd_data: got %h expected %h", o_data, exp_q[0]);
            else n_pass++;
            void'(exp_q.pop_front());
        end
        if (w_wr) pend_q.push_back(d);
        if (x) pend_q.delete();
        else if (c) while (pend_q.size() != 0) exp_q.push_back(pend_q.pop_front());
        @(posedge clk);
        #1;
        wr = 1'b0; cm = 1'b0; dc = 1'b0; rd = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * FLEN && exp_q.size() != 0; i++) step(0, '0, 0, 0, 1);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete(); pend_q.delete();
        n_checks++;
        if ({o_empty, o_aempty, o_full, o_afull} !== 4'b1100)
            $display("FAIL reset_flags: got %b expected 1100", {o_empty, o_aempty, o_full, o_afull});
        else n_pass++;
        n_checks++;
        if ({o_fill, o_avail, o_pending} !== '0)
            $display("FAIL reset_counts: got %0d/%0d/%0d expected 0/0/0", o_fill, o_avail, o_pending);
        else n_pass++;
    endtask

    task automatic test_commit();
        logic [BW-1:0] words [3];
        words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33;
        for (int i = 0; i < 3; i++) begin
            step(1, words[i], 0, 0, 0);
            n_checks++;
            if (o_pending !== PW'(i + 1) || o_fill !== PW'(i + 1) || o_empty !== 1'b1)
                $display("FAIL commit_pending: got pend=%0d fill=%0d empty=%b expected %0d/%0d/1",
                         o_pending, o_fill, o_empty, i + 1, i + 1);
            else n_pass++;
        end
        step(0, '0, 1, 0, 0);
        n_checks++;
        if (o_avail !== 3'd3 || o_empty !== 1'b0 || o_aempty !== 1'b0 || o_pending !== 3'd0)
            $display("FAIL commit_avail: got avail=%0d empty=%b aempty=%b pend=%0d expected 3/0/0/0",
                     o_avail, o_empty, o_aempty, o_pending);
        else n_pass++;
        n_checks++;
        if (o_data !== 32'h11) $display("FAIL commit_head: got %h expected 00000011", o_data);
        else n_pass++;
        drain();
        n_checks++;
        if (o_empty !== 1'b1 || o_fill !== 3'd0)
            $display("FAIL commit_drain: got empty=%b fill=%0d expected 1/0", o_empty, o_fill);
        else n_pass++;
    endtask

    task automatic test_discard();
        for (int i = 0; i < 3; i++) step(1, 32'hD0 + i, 0, 0, 0);
        step(1, 32'hD3, 0, 1, 0);
        n_checks++;
        if (o_fill !== 3'd0 || o_pending !== 3'd0 || o_empty !== 1'b1)
            $display("FAIL discard_drop: got fill=%0d pend=%0d empty=%b expected 0/0/1",
                     o_fill, o_pending, o_empty);
        else n_pass++;
        step(1, 32'hAA, 1, 0, 0);
        n_checks++;
        if (o_data !== 32'hAA || o_avail !== 3'd1)
            $display("FAIL discard_next: got data=%h avail=%0d expected 000000aa/1", o_data, o_avail);
        else n_pass++;
        drain();
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) step(1, 32'hF0 + i, (i == 3), 0, 0);
        n_checks++;
        if (o_full !== 1'b1 || o_afull !== 1'b1 || o_fill !== 3'd4 || o_avail !== 3'd4)
            $display("FAIL full_set: got full=%b afull=%b fill=%0d avail=%0d expected 1/1/4/4",
                     o_full, o_afull, o_fill, o_avail);
        else n_pass++;
        step(1, 32'h99, 0, 0, 0);
        n_checks++;
        if (o_fill !== 3'd4 || o_pending !== 3'd0)
            $display("FAIL full_ignore: got fill=%0d pend=%0d expected 4/0", o_fill, o_pending);
        else n_pass++;
        step(1, 32'h55, 0, 0, 1);
        n_checks++;
        if (o_fill !== 3'd3 || o_full !== 1'b0 || o_afull !== 1'b1)
            $display("FAIL full_rdwr: got fill=%0d full=%b afull=%b expected 3/0/1", o_fill, o_full, o_afull);
        else n_pass++;
        step(1, 32'h66, 1, 0, 1);
        n_checks++;
        if (o_fill !== 3'd3 || o_avail !== 3'd3)
            $display("FAIL simul_rdwr: got fill=%0d avail=%0d expected 3/3", o_fill, o_avail);
        else n_pass++;
        drain();
    endtask

    task automatic test_commit_discard();
        step(1, 32'h77, 1, 0, 0);
        step(1, 32'h81, 0, 0, 0);
        step(1, 32'h82, 0, 0, 0);
        step(0, '0, 1, 1, 0);
        n_checks++;
        if (o_pending !== 3'd0 || o_avail !== 3'd1 || o_fill !== 3'd1)
            $display("FAIL cmdc_both: got pend=%0d avail=%0d fill=%0d expected 0/1/1",
                     o_pending, o_avail, o_fill);
        else n_pass++;
        drain();
        n_checks++;
        if (o_empty !== 1'b1) $display("FAIL cmdc_empty: got %b expected 1", o_empty);
        else n_pass++;
    endtask

    task automatic test_read_discard();
        step(1, 32'h90, 1, 0, 0);
        step(1, 32'h91, 0, 0, 0);
        step(0, '0, 0, 1, 1);
        n_checks++;
        if (o_fill !== 3'd0 || o_avail !== 3'd0 || o_pending !== 3'd0 || o_empty !== 1'b1)
            $display("FAIL rd_discard: got fill=%0d avail=%0d pend=%0d empty=%b expected 0/0/0/1",
                     o_fill, o_avail, o_pending, o_empty);
        else n_pass++;
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 16 * FLEN; i++) begin
            step($urandom_range(0, 3) != 0, $urandom, (i % 2) == 1, 0, 1);
            n_checks++;
            if (o_avail !== PW'(exp_q.size()) || o_fill !== PW'(m_fill()) ||
                o_pending !== PW'(pend_q.size()) || o_empty !== (exp_q.size() == 0))
                $display("FAIL wrap_cnt: got avail=%0d fill=%0d pend=%0d empty=%b expected %0d/%0d/%0d",
                         o_avail, o_fill, o_pending, o_empty, exp_q.size(), m_fill(), pend_q.size());
            else n_pass++;
        end
        step(0, '0, 1, 0, 0);
        drain();
        n_checks++;
        if (o_fill !== 3'd0 || o_empty !== 1'b1)
            $display("FAIL wrap_end: got fill=%0d empty=%b expected 0/1", o_fill, o_empty);
        else n_pass++;
    endtask

`ifdef SDPKTFIFO_ERRFLAGS_EN
    task automatic test_errflags();
        step(0, '0, 0, 0, 1);
        n_checks++;
        if (unf !== 1'b1) $display("FAIL underflow_set: got %b expected 1", unf);
        else n_pass++;
        step(0, '0, 0, 0, 0);
        n_checks++;
        if (unf !== 1'b1 || ovf !== 1'b0)
            $display("FAIL underflow_sticky: got unf=%b ovf=%b expected 1/0", unf, ovf);
        else n_pass++;
        @(negedge clk);
        clrerr = 1'b1;
        @(posedge clk);
        #1;
        clrerr = 1'b0;
        n_checks++;
        if (unf !== 1'b0) $display("FAIL underflow_clr: got %b expected 0", unf);
        else n_pass++;
    endtask
`endif

    initial begin
        rst = 1'b1; wr = 1'b0; cm = 1'b0; dc = 1'b0; rd = 1'b0; din = '0;
`ifdef SDPKTFIFO_ERRFLAGS_EN
        clrerr = 1'b0;
`endif
        test_reset();
        test_commit();
        test_discard();
        test_full();
        test_commit_discard();
        test_read_discard();
        test_wrap();
`ifdef SDPKTFIFO_ERRFLAGS_EN
        test_errflags();
`endif
        test_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
